// File: rtl/poly_rr_scheduler.sv
// Time-shared Horner evaluator y = ((a*x)+b)*x + c with round-robin arbitration of two requesters.
// Define POLY_SAT_EN for saturating arithmetic and the sticky resp_sat output.
module poly_rr_scheduler #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [4*DATA_W-1:0]   req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [4*DATA_W-1:0]   req1_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [DATA_W-1:0]     resp_data,
`ifdef POLY_SAT_EN
  output logic                  resp_sat,
`endif
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_C0, S_C1, S_C2, S_C3, S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   acc, b_r, c_r, x_r;
  logic                id_r, last_grant;
  logic                winner, accept;
  logic [4*DATA_W-1:0] win_data;
  logic                is_mul, is_op;
  logic [DATA_W-1:0]   add_opnd, alu_y;
`ifdef POLY_SAT_EN
  logic [2*DATA_W-1:0] prod_full;
  logic [DATA_W:0]     sum_full;
  logic                alu_ovf;
  logic                sat_r;
`endif

  // Ties go to whichever requester was not served last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    winner = 1'b0;
    if (req0_valid && req1_valid) winner = ~last_grant;
    else if (req1_valid)          winner = 1'b1;
  end

  assign accept   = (state == S_IDLE) && (req0_valid || req1_valid);
  assign win_data = winner ? req1_data : req0_data;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_C0;
      S_C0:    state_nx = S_C1;
      S_C1:    state_nx = S_C2;
      S_C2:    state_nx = S_C3;
      S_C3:    state_nx = S_DONE;
      S_DONE:  if (resp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready = (state == S_IDLE) && !winner && req0_valid;
    req1_ready = (state == S_IDLE) &&  winner && req1_valid;
    resp_valid = (state == S_DONE);
    busy       = (state != S_IDLE);
    resp_data  = acc;
    resp_id    = id_r;
  end

  // Shared ALU: multiply by x in C0/C2, add b in C1 and c in C3.
  assign is_mul   = (state == S_C0) || (state == S_C2);
  assign is_op    = (state == S_C0) || (state == S_C1) || (state == S_C2) || (state == S_C3);
  assign add_opnd = (state == S_C3) ? c_r : b_r;

`ifdef POLY_SAT_EN
  always_comb begin
    prod_full = acc * x_r;
    sum_full  = {1'b0, acc} + {1'b0, add_opnd};
    alu_ovf   = is_mul ? (|prod_full[2*DATA_W-1:DATA_W]) : sum_full[DATA_W];
    if (alu_ovf)     alu_y = '1;
    else if (is_mul) alu_y = prod_full[DATA_W-1:0];
    else             alu_y = sum_full[DATA_W-1:0];
  end
  assign resp_sat = sat_r;
`else
  always_comb begin
    if (is_mul) alu_y = acc * x_r;
    else        alu_y = acc + add_opnd;
  end
`endif

  // Datapath registers; a reset anywhere discards the in-flight result.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc        <= '0;
      b_r        <= '0;
      c_r        <= '0;
      x_r        <= '0;
      id_r       <= 1'b0;
      last_grant <= 1'b1;
`ifdef POLY_SAT_EN
      sat_r      <= 1'b0;
`endif
    end else if (accept) begin
      acc        <= win_data[4*DATA_W-1:3*DATA_W];
      b_r        <= win_data[3*DATA_W-1:2*DATA_W];
      c_r        <= win_data[2*DATA_W-1:DATA_W];
      x_r        <= win_data[DATA_W-1:0];
      id_r       <= winner;
      last_grant <= winner;
`ifdef POLY_SAT_EN
      sat_r      <= 1'b0;
`endif
    end else if (is_op) begin
      acc        <= alu_y;
`ifdef POLY_SAT_EN
      if (alu_ovf) sat_r <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_poly_rr_scheduler.sv
// Directed self-checking bench for poly_rr_scheduler; inputs change and outputs are sampled on the falling edge.
module tb_poly_rr_scheduler;

  logic        clk;
  logic        resetn;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_data;
  logic        resp_valid, resp_ready, resp_id;
  logic [7:0]  resp_data;
  logic        busy;
`ifdef POLY_SAT_EN
  logic        resp_sat;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  poly_rr_scheduler #(.DATA_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
`ifdef POLY_SAT_EN
    .resp_sat   (resp_sat),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Waits for resp_valid; reports whether it came, when, and whether any ready rose meanwhile.
  task automatic wait_resp(input int max_cyc, output bit ok, output int cyc, output bit rdy_seen);
    ok = 1'b0;
    rdy_seen = 1'b0;
    cyc = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (resp_valid) begin
        ok = 1'b1;
        cyc = c;
        break;
      end
      rdy_seen = rdy_seen | req0_ready | req1_ready;
      @(negedge clk);
    end
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({resp_valid, busy, resp_id, resp_data} !== 11'd0)
      $display("FAIL reset_outputs: got valid=%b busy=%b id=%b data=%0d expected all 0", resp_valid, busy, resp_id, resp_data);
    else n_pass++;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b00)
      $display("FAIL reset_ready_idle: got %b expected 00", {req1_ready, req0_ready});
    else n_pass++;
    req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b10)
      $display("FAIL reset_single_req1: got %b expected 10", {req1_ready, req0_ready});
    else n_pass++;
    req1_valid = 1'b0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1;
    req0_data  = {8'd2, 8'd3, 8'd4, 8'd5};
    #1;
    n_checks++;
    if ({req1_ready, req0_ready, busy} !== 3'b010)
      $display("FAIL single_accept: got r1=%b r0=%b busy=%b expected 0 1 0", req1_ready, req0_ready, busy);
    else n_pass++;
    @(negedge clk);
    req0_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      n_checks++;
      if ({busy, resp_valid} !== {1'b1, k == 5})
        $display("FAIL single_latency_c%0d: got busy=%b valid=%b expected busy=1 valid=%b", k, busy, resp_valid, k == 5);
      else n_pass++;
    end
    n_checks++;
    if ({resp_id, resp_data} !== {1'b0, 8'd69})
      $display("FAIL single_result: got id=%b data=%0d expected id=0 data=69", resp_id, resp_data);
    else n_pass++;
`ifdef POLY_SAT_EN
    n_checks++;
    if (resp_sat !== 1'b0) $display("FAIL single_sat: got %b expected 0", resp_sat);
    else n_pass++;
`endif
    take_resp();
    n_checks++;
    if ({busy, resp_valid} !== 2'b00)
      $display("FAIL single_idle: got busy=%b valid=%b expected 0 0", busy, resp_valid);
    else n_pass++;
  endtask

  task automatic test_tie();
    bit ok, rdy;
    int cyc;
    do_reset();
    req0_valid = 1'b1; req0_data = {8'd1, 8'd1, 8'd1, 8'd3};
    req1_valid = 1'b1; req1_data = {8'd2, 8'd0, 8'd0, 8'd2};
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL tie_first_grant: got %b expected 01", {req1_ready, req0_ready});
    else n_pass++;
    @(negedge clk);
    req0_valid = 1'b0;
    wait_resp(10, ok, cyc, rdy);
    n_checks++;
    if ({ok, rdy, cyc} !== {1'b1, 1'b0, 32'd5})
      $display("FAIL tie_resp0_timing: got ok=%b ready_seen=%b cycle=%0d expected 1 0 5", ok, rdy, cyc);
    else n_pass++;
    n_checks++;
    if ({resp_id, resp_data, req1_ready} !== {1'b0, 8'd13, 1'b0})
      $display("FAIL tie_resp0: got id=%b data=%0d r1=%b expected id=0 data=13 r1=0", resp_id, resp_data, req1_ready);
    else n_pass++;
    take_resp();
    n_checks++;
    if (req1_ready !== 1'b1) $display("FAIL tie_req1_ready: got %b expected 1", req1_ready);
    else n_pass++;
    @(negedge clk);
    req1_valid = 1'b0;
    wait_resp(10, ok, cyc, rdy);
    n_checks++;
    if ({ok, resp_id, resp_data} !== {1'b1, 1'b1, 8'd8})
      $display("FAIL tie_resp1: got ok=%b id=%b data=%0d expected 1 1 8", ok, resp_id, resp_data);
    else n_pass++;
    take_resp();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL tie_second_grant: got %b expected 01", {req1_ready, req0_ready});
    else n_pass++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok, rdy;
    int cyc;
    req0_valid = 1'b1;
    req0_data  = {8'd16, 8'd0, 8'd0, 8'd16};
    @(negedge clk);
    req0_valid = 1'b0;
    wait_resp(10, ok, cyc, rdy);
`ifdef POLY_SAT_EN
    n_checks++;
    if ({ok, resp_data, resp_sat} !== {1'b1, 8'd255, 1'b1})
      $display("FAIL wrap_sat: got ok=%b data=%0d sat=%b expected 1 255 1", ok, resp_data, resp_sat);
    else n_pass++;
`else
    n_checks++;
    if ({ok, resp_data} !== {1'b1, 8'd0})
      $display("FAIL wrap_result: got ok=%b data=%0d expected 1 0", ok, resp_data);
    else n_pass++;
`endif
    take_resp();
  endtask

  task automatic test_backpressure();
    bit ok, rdy;
    int cyc;
    req0_valid = 1'b1;
    req0_data  = {8'd2, 8'd3, 8'd4, 8'd5};
    @(negedge clk);
    req0_valid = 1'b0;
    req0_data  = 32'hFFFF_FFFF;
    req1_valid = 1'b1;
    req1_data  = {8'd1, 8'd1, 8'd1, 8'd3};
    wait_resp(10, ok, cyc, rdy);
    n_checks++;
    if ({ok, rdy} !== 2'b10)
      $display("FAIL bp_wait: got ok=%b ready_seen=%b expected 1 0", ok, rdy);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({resp_valid, resp_id, resp_data, req1_ready} !== {1'b1, 1'b0, 8'd69, 1'b0})
        $display("FAIL bp_hold_%0d: got v=%b id=%b data=%0d r1=%b expected 1 0 69 0", k, resp_valid, resp_id, resp_data, req1_ready);
      else n_pass++;
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req1_ready !== 1'b0) $display("FAIL bp_ready_in_done: got %b expected 0", req1_ready);
    else n_pass++;
    @(negedge clk);
    resp_ready = 1'b0;
    n_checks++;
    if ({busy, req1_ready} !== 2'b01)
      $display("FAIL bp_return_idle: got busy=%b r1=%b expected 0 1", busy, req1_ready);
    else n_pass++;
    @(negedge clk);
    req1_valid = 1'b0;
    wait_resp(10, ok, cyc, rdy);
    n_checks++;
    if ({ok, resp_id, resp_data} !== {1'b1, 1'b1, 8'd13})
      $display("FAIL bp_req1_result: got ok=%b id=%b data=%0d expected 1 1 13", ok, resp_id, resp_data);
    else n_pass++;
    take_resp();
  endtask

  task automatic test_reset_mid();
    bit stale;
    req0_valid = 1'b1;
    req0_data  = {8'd2, 8'd3, 8'd4, 8'd5};
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    n_checks++;
    if ({busy, resp_valid, resp_id, resp_data} !== 11'd0)
      $display("FAIL midreset_state: got busy=%b v=%b id=%b data=%0d expected all 0", busy, resp_valid, resp_id, resp_data);
    else n_pass++;
    stale = 1'b0;
    for (int k = 0; k < 8; k++) begin
      stale = stale | resp_valid | busy;
      @(negedge clk);
    end
    n_checks++;
    if (stale !== 1'b0) $display("FAIL midreset_stale: got activity=%b expected 0", stale);
    else n_pass++;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL midreset_tie: got %b expected 01", {req1_ready, req0_ready});
    else n_pass++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_fairness();
    bit ok, rdy;
    int cyc;
    bit exp_id;
    do_reset();
    req0_data  = {8'd2, 8'd3, 8'd4, 8'd5};
    req1_data  = {8'd1, 8'd1, 8'd1, 8'd3};
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_id = i[0];
      #1;
      n_checks++;
      if ({req1_ready, req0_ready} !== {exp_id, ~exp_id})
        $display("FAIL fair_grant_%0d: got %b expected %b", i, {req1_ready, req0_ready}, {exp_id, ~exp_id});
      else n_pass++;
      @(negedge clk);
      wait_resp(10, ok, cyc, rdy);
      n_checks++;
      if ({ok, rdy, resp_id, resp_data} !== {1'b1, 1'b0, exp_id, exp_id ? 8'd13 : 8'd69})
        $display("FAIL fair_resp_%0d: got ok=%b rdy=%b id=%b data=%0d expected 1 0 %b %0d",
                 i, ok, rdy, resp_id, resp_data, exp_id, exp_id ? 13 : 69);
      else n_pass++;
      take_resp();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    resetn     = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    resp_ready = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_fairness();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
